// File: rtl/even_parity_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, even parity, stop bit.
// Bits are consumed only on sample_en strobes; results are registered with a one-cycle valid pulse.
module even_parity_frame_receiver #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              sample_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic              acc;
  logic              frame_bad;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Only meaningful while sampling the stop bit: acc already covers data and parity.
  assign frame_bad = acc | ~din;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shift_reg  <= '0;
      acc        <= 1'b0;
      data       <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      out_valid <= 1'b0;
      if (sample_en) begin
        case (state)
          IDLE: begin
            if (!din) begin
              state   <= DATA;
              bit_idx <= '0;
              acc     <= 1'b0;
            end
          end
          DATA: begin
            shift_reg[bit_idx] <= din;
            acc                <= acc ^ din;
            if (bit_idx == LAST_IDX) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          PARITY: begin
            acc   <= acc ^ din;
            state <= STOP;
          end
          STOP: begin
            state      <= IDLE;
            data       <= shift_reg;
            parity_err <= acc;
            frame_err  <= ~din;
            out_valid  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end

      // Clear takes priority over a coincident error increment.
      if (err_clr) begin
        err_cnt <= 8'd0;
      end else if (sample_en && (state == STOP) && frame_bad) begin
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_even_parity_frame_receiver.sv
// Bench for even_parity_frame_receiver: table of frames plus hand sequences,
// with a queue of expected results checked whenever out_valid pulses.
module tb_even_parity_frame_receiver;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b1;
  logic          sample_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] data;
  logic          out_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
  logic [7:0]    err_cnt;

  even_parity_frame_receiver #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .sample_en (sample_en),
    .err_clr   (err_clr),
    .data      (data),
    .out_valid (out_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int model_err = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [DW-1:0] d;
    logic          par;
    logic          stop;
    int            gap;
    logic [DW-1:0] ed;
    logic          ep;
    logic          ef;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL ov_unexpected: out_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ov_latency", cyc, e.cyc);
        check("data", 32'(data), 32'(e.data));
        check("parity_err", 32'(parity_err), 32'(e.perr));
        check("frame_err", 32'(frame_err), 32'(e.ferr));
      end
    end
  end

  task automatic send_bit(input logic b, input int gap, input logic exp_busy);
    @(negedge clk);
    din = b;
    sample_en = 1'b1;
    err_clr = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      sample_en = 1'b0;
      din = 1'($urandom);
      check("busy_gap", 32'(busy), 32'(exp_busy));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop,
                            input int gap, input logic [DW-1:0] ed, input logic ep,
                            input logic ef, input bit settle, input bit clr);
    exp_t e;
    send_bit(1'b0, gap, 1'b1);
    for (int i = 0; i < DW; i++) send_bit(d[i], gap, 1'b1);
    send_bit(par, gap, 1'b1);
    @(negedge clk);
    din = stop;
    sample_en = 1'b1;
    err_clr = clr;
    e.data = ed; e.perr = ep; e.ferr = ef; e.cyc = cyc + 1;
    sb.push_back(e);
    if (clr) model_err = 0;
    else if ((ep | ef) && model_err < 255) model_err++;
    repeat (gap) begin
      @(negedge clk);
      sample_en = 1'b0;
      err_clr = 1'b0;
      din = 1'($urandom);
      check("busy_after_stop", 32'(busy), 32'd0);
    end
    if (settle) begin
      @(negedge clk);
      sample_en = 1'b0;
      err_clr = 1'b0;
      din = 1'b1;
      check("busy_idle", 32'(busy), 32'd0);
      check("err_cnt", 32'(err_cnt), 32'(model_err));
    end
  endtask

  initial begin
    vecs[0] = '{4'hB, 1'b1, 1'b1, 0, 4'hB, 1'b0, 1'b0};
    vecs[1] = '{4'hB, 1'b0, 1'b1, 0, 4'hB, 1'b1, 1'b0};
    vecs[2] = '{4'hB, 1'b1, 1'b0, 0, 4'hB, 1'b0, 1'b1};
    vecs[3] = '{4'hB, 1'b1, 1'b1, 2, 4'hB, 1'b0, 1'b0};
    vecs[4] = '{4'h5, 1'b0, 1'b1, 1, 4'h5, 1'b0, 1'b0};
    vecs[5] = '{4'h0, 1'b0, 1'b1, 0, 4'h0, 1'b0, 1'b0};
    vecs[6] = '{4'hF, 1'b0, 1'b1, 3, 4'hF, 1'b0, 1'b0};
    vecs[7] = '{4'hF, 1'b1, 1'b1, 0, 4'hF, 1'b1, 1'b0};
    vecs[8] = '{4'h6, 1'b0, 1'b0, 0, 4'h6, 1'b0, 1'b1};
    vecs[9] = '{4'h7, 1'b0, 1'b0, 1, 4'h7, 1'b1, 1'b1};

    // Reset with other inputs active
    rst = 1'b1; sample_en = 1'b1; din = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0; sample_en = 1'b0; din = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, vecs[i].gap,
                 vecs[i].ed, vecs[i].ep, vecs[i].ef, 1'b1, 1'b0);

    // Back-to-back frames with no idle strobe between them
    send_frame(4'h3, 1'b0, 1'b1, 0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'h8, 1'b1, 1'b1, 0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset after three data bits discards the partial frame
    send_bit(1'b0, 0, 1'b1);
    send_bit(1'b1, 0, 1'b1);
    send_bit(1'b0, 0, 1'b1);
    send_bit(1'b1, 0, 1'b1);
    @(negedge clk);
    rst = 1'b1; sample_en = 1'b1; din = 1'b0;
    @(negedge clk);
    rst = 1'b0; sample_en = 1'b0; din = 1'b1;
    model_err = 0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    send_frame(4'h5, 1'b0, 1'b1, 0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);

    // Saturation of the error counter, then clear against a coincident error
    for (int i = 0; i < 260; i++)
      send_frame(4'hB, 1'b0, 1'b1, 0, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    sample_en = 1'b0; din = 1'b1;
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
    send_frame(4'hB, 1'b0, 1'b1, 0, 4'hB, 1'b1, 1'b0, 1'b1, 1'b1);
    check("err_cnt_clr_wins", 32'(err_cnt), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
